// File: rtl/grf_hazard_pkg.sv
// Shared constants for the GRF hazard scoreboard: table geometry, forwarding
// codes, Tuse/Tnew encodings and the stage-distance to forward-code mapping.
package grf_hazard_pkg;

  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);
  localparam int TW   = 2;

  // Cycles from issue until write-back completes (E, M, W).
  localparam logic [TW-1:0] LIFE = 2'd3;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  localparam logic [TW-1:0] TUSE_NONE = 2'd3;

  localparam logic [TW-1:0] TNEW_LINK = 2'd0;
  localparam logic [TW-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TW-1:0] TNEW_LOAD = 2'd2;

  // Remaining life tells which stage holds the producer.
  function automatic logic [1:0] fwd_code(input logic [TW-1:0] life);
    case (life)
      2'd3:    fwd_code = FWD_E;
      2'd2:    fwd_code = FWD_M;
      2'd1:    fwd_code = FWD_W;
      default: fwd_code = FWD_GRF;
    endcase
  endfunction

endpackage

// File: rtl/grf_sb_entry.sv
// One register's in-flight writer: life and Tnew counters that load on issue,
// clear when their writer is flushed from E, and otherwise count down to 0.
module grf_sb_entry
  import grf_hazard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          issue,
  input  logic          flush,
  input  logic [TW-1:0] tnew_in,
  output logic [TW-1:0] life,
  output logic [TW-1:0] tnew
);

  // NOTE: the table is built from flops rather than a RAM, so every entry is
  // cleared by the asynchronous reset and nothing stale survives a pipeline reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      life <= '0;
      tnew <= '0;
    end else if (issue) begin
      // NOTE: non-blocking assignments, so the hazard logic always sees the
      // pre-edge table and the newest writer simply overwrites the old one.
      life <= LIFE;
      tnew <= tnew_in;
    end else if (flush && life == LIFE) begin
      life <= '0;
      tnew <= '0;
    end else begin
      life <= (life != '0) ? life - 1'b1 : '0;
      tnew <= (tnew != '0) ? tnew - 1'b1 : '0;
    end
  end

endmodule

// File: rtl/grf_scoreboard.sv
// GRF hazard controller: per-register writer table, D-stage stall decision,
// forwarding-source report and a saturating stalled-cycle counter.
module grf_scoreboard
  import grf_hazard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic [TW-1:0] rs_tuse,
  input  logic [TW-1:0] rt_tuse,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [TW-1:0] wr_tnew,
  input  logic          md_use,
  input  logic          md_busy,
  input  logic          flush,
  output logic          stall,
  output logic [1:0]    rs_fwd,
  output logic [1:0]    rt_fwd,
  output logic [15:0]   stall_cycles
);

  logic [TW-1:0] life_q [NREG];
  logic [TW-1:0] tnew_q [NREG];
  logic          rs_haz;
  logic          rt_haz;
  logic          md_haz;
  logic          accept;

  // Register 0 never holds a writer.
  assign life_q[0] = '0;
  assign tnew_q[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_entry
    grf_sb_entry u_entry (
      .clk     (clk),
      .reset   (reset),
      .issue   (accept && (wr_addr == AW'(i))),
      .flush   (flush),
      .tnew_in (wr_tnew),
      .life    (life_q[i]),
      .tnew    (tnew_q[i])
    );
  end

  // A pending writer blocks only if its result arrives after the operand is needed.
  assign rs_haz = (rs_addr != '0) && (life_q[rs_addr] != '0) && (tnew_q[rs_addr] > rs_tuse);
  assign rt_haz = (rt_addr != '0) && (life_q[rt_addr] != '0) && (tnew_q[rt_addr] > rt_tuse);
  assign md_haz = md_use && md_busy;

  assign stall  = issue_valid && (rs_haz || rt_haz || md_haz);
  assign accept = issue_valid && !stall && wr_en && (wr_addr != '0);

  assign rs_fwd = (rs_addr == '0) ? FWD_GRF : fwd_code(life_q[rs_addr]);
  assign rt_fwd = (rt_addr == '0) ? FWD_GRF : fwd_code(life_q[rt_addr]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (stall && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Scoreboard bench for grf_scoreboard: a driver pushes expectations from a
// timestamp-based writer model, a negedge monitor pops and compares them.
module tb_grf_scoreboard;
  import grf_hazard_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [1:0]  rs_tuse = 2'd3;
  logic [1:0]  rt_tuse = 2'd3;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [1:0]  wr_tnew = '0;
  logic        md_use = 1'b0;
  logic        md_busy = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [1:0]  rs_fwd;
  logic [1:0]  rt_fwd;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  grf_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_tuse      (rs_tuse),
    .rt_tuse      (rt_tuse),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_tnew      (wr_tnew),
    .md_use       (md_use),
    .md_busy      (md_busy),
    .flush        (flush),
    .stall        (stall),
    .rs_fwd       (rs_fwd),
    .rt_fwd       (rt_fwd),
    .stall_cycles (stall_cycles)
  );

  typedef struct packed {
    logic        stall;
    logic [1:0]  rs_fwd;
    logic [1:0]  rt_fwd;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Model: newest writer per register as (cycle it becomes visible, Tnew at issue).
  bit m_valid[NREG];
  int m_vis[NREG];
  int m_t[NREG];
  int m_cyc;
  int m_cnt;

  function automatic int m_age(int r);
    return m_cyc - m_vis[r];
  endfunction

  function automatic bit m_pend(int r);
    return (r != 0) && m_valid[r] && (m_age(r) < 3);
  endfunction

  function automatic int m_tnew(int r);
    int v;
    v = m_t[r] - m_age(r);
    return (v < 0) ? 0 : v;
  endfunction

  // Age 0 is in E, 1 in M, 2 in W.
  function automatic logic [1:0] m_fwd(int r);
    if (!m_pend(r)) return 2'd0;
    return 2'(m_age(r) + 1);
  endfunction

  function automatic bit m_haz(int r, int tuse);
    return m_pend(r) && (m_tnew(r) > tuse);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic core(input bit in_rst, input bit iv, input int rsa, input int rta,
                      input int rsu, input int rtu, input bit we, input int wa,
                      input int wt, input bit mu, input bit mb, input bit fl);
    bit   s;
    exp_t e;
    @(posedge clk);
    #1;
    reset       = in_rst ? 1'b0 : 1'b1;
    issue_valid = iv;
    rs_addr     = 5'(rsa);
    rt_addr     = 5'(rta);
    rs_tuse     = 2'(rsu);
    rt_tuse     = 2'(rtu);
    wr_en       = we;
    wr_addr     = 5'(wa);
    wr_tnew     = 2'(wt);
    md_use      = mu;
    md_busy     = mb;
    flush       = fl;
    if (in_rst) begin
      for (int r = 0; r < NREG; r++) m_valid[r] = 1'b0;
      m_cyc = 0;
      m_cnt = 0;
    end
    s = iv && (m_haz(rsa, rsu) || m_haz(rta, rtu) || (mu && mb));
    e.stall  = s;
    e.rs_fwd = m_fwd(rsa);
    e.rt_fwd = m_fwd(rta);
    e.cnt    = 16'(m_cnt);
    exp_q.push_back(e);
    if (!in_rst) begin
      if (s && m_cnt < 65535) m_cnt++;
      if (fl)
        for (int r = 1; r < NREG; r++)
          if (m_pend(r) && m_age(r) == 0) m_valid[r] = 1'b0;
      if (iv && !s && we && wa != 0) begin
        m_valid[wa] = 1'b1;
        m_vis[wa]   = m_cyc + 1;
        m_t[wa]     = wt;
      end
      m_cyc++;
    end
  endtask

  task automatic step(input bit iv, input int rsa, input int rta, input int rsu,
                      input int rtu, input bit we, input int wa, input int wt,
                      input bit mu, input bit mb, input bit fl);
    core(1'b0, iv, rsa, rta, rsu, rtu, we, wa, wt, mu, mb, fl);
  endtask

  task automatic do_reset(input bit iv, input bit mu, input bit mb);
    core(1'b1, iv, 0, 0, 3, 3, 1'b0, 0, 0, mu, mb, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stall", 32'(stall), 32'(e.stall));
      check("rs_fwd", 32'(rs_fwd), 32'(e.rs_fwd));
      check("rt_fwd", 32'(rt_fwd), 32'(e.rt_fwd));
      check("stall_cycles", 32'(stall_cycles), 32'(e.cnt));
    end
  end

  initial begin
    do_reset(0, 0, 0);

    // Load then use: one stall, then forward from M.
    step(1, 0, 0, 3, 3, 1, 8, 2, 0, 0, 0);
    step(1, 8, 0, 1, 3, 1, 10, 1, 0, 0, 0);
    step(1, 8, 0, 1, 3, 1, 10, 1, 0, 0, 0);
    idle(3);

    // ALU back-to-back with tuse 0, then tuse 1.
    step(1, 0, 0, 3, 3, 1, 9, 1, 0, 0, 0);
    step(1, 9, 9, 0, 3, 0, 0, 0, 0, 0, 0);
    step(1, 9, 9, 0, 3, 0, 0, 0, 0, 0, 0);
    idle(3);
    step(1, 0, 0, 3, 3, 1, 9, 1, 0, 0, 0);
    step(1, 9, 0, 1, 3, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Register zero never creates an entry.
    step(1, 0, 0, 3, 3, 1, 0, 2, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Overwrite: the newer ALU writer wins.
    step(1, 0, 0, 3, 3, 1, 5, 2, 0, 0, 0);
    step(1, 0, 0, 3, 3, 1, 5, 1, 0, 0, 0);
    step(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
    step(1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Flush kills the load in E.
    step(1, 0, 0, 3, 3, 1, 4, 2, 0, 0, 0);
    step(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1);
    step(1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Mult/div stall counting, then asynchronous reset mid-stall.
    do_reset(0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 3, 3, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 3, 3, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 3, 3, 1, 7, 2, 0, 0, 0);
    step(1, 7, 0, 0, 3, 0, 0, 0, 1, 1, 0);
    do_reset(1, 1, 1);
    step(1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 9) < 8,
           $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 2),
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0);
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
